// File: rtl/tawas_regfile_mp.sv
// Multi-threaded register file. Each thread context holds NREGS registers plus a
// flags field. Several writeback ports merge into one pipelined write per cycle.
// Loads see that pending write through a bypass.
// After reset, an INIT sweep clears every context before `ready` rises.
module tawas_regfile_mp #(
   parameter int THREADS = 32,
   parameter int NREGS   = 8,
   parameter int DW      = 32,
   parameter int FW      = 8,
   parameter int NWB     = 3,
   localparam int TW     = $clog2(THREADS),
   localparam int RW     = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ready,
   input  logic                 thread_load_en,
   input  logic [TW-1:0]        thread_load,
   output logic [NREGS*DW-1:0]  rdata,
   output logic [FW-1:0]        rflags,
   input  logic [TW-1:0]        wb_thread,
   input  logic [NWB-1:0]       wb_en,
   input  logic [NWB*RW-1:0]    wb_reg,
   input  logic [NWB*DW-1:0]    wb_data,
   input  logic                 wb_flags_en,
   input  logic [FW-1:0]        wb_flags,
   output logic                 wb_conflict
);

   // Context layout: registers in the low NREGS*DW bits, flags on top.
   localparam int CW = NREGS*DW + FW;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               state_q;
   logic [TW-1:0]        cnt_q;
   logic                 ready_q;
   logic [NREGS*DW-1:0]  rdata_q;
   logic [FW-1:0]        rflags_q;
   logic                 conflict_q;

   logic [CW-1:0]        mem_q [THREADS];

   logic                 s1_vld_q;
   logic [TW-1:0]        s1_thread_q;
   logic [CW-1:0]        s1_data_q;
   logic [CW-1:0]        s1_mask_q;

   logic [CW-1:0]        s1_data_d;
   logic [CW-1:0]        s1_mask_d;
   logic                 conflict_d;
   logic                 wr_any_d;
   logic [CW-1:0]        ld_word_d;

   // Merge all writeback ports into a single lane-masked write.
   // Later ports overwrite earlier ones, so the highest enabled port wins a lane.
   always_comb begin
      logic [NREGS-1:0] lane_hit;
      int unsigned      lane;
      s1_data_d  = '0;
      s1_mask_d  = '0;
      conflict_d = 1'b0;
      lane_hit   = '0;
      lane       = 0;
      for (int p = 0; p < NWB; p++) begin
         if (wb_en[p]) begin
            lane = int'(wb_reg[p*RW +: RW]);
            if (lane_hit[lane]) conflict_d = 1'b1;
            lane_hit[lane] = 1'b1;
            s1_data_d[lane*DW +: DW] = wb_data[p*DW +: DW];
            s1_mask_d[lane*DW +: DW] = '1;
         end
      end
      if (wb_flags_en) begin
         s1_data_d[NREGS*DW +: FW] = wb_flags;
         s1_mask_d[NREGS*DW +: FW] = '1;
      end
      wr_any_d = (|wb_en) | wb_flags_en;
   end

   // Load view of the requested context, with the not-yet-committed S1 write folded in.
   always_comb begin
      ld_word_d = mem_q[thread_load];
      if (s1_vld_q && (s1_thread_q == thread_load))
         ld_word_d = (ld_word_d & ~s1_mask_q) | s1_data_q;
   end

   // Control FSM: INIT sweep, then RUN. Also drives the registered outputs and S1 valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         s1_vld_q   <= 1'b0;
         rdata_q    <= '0;
         rflags_q   <= '0;
         conflict_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_q      <= cnt_q + 1'b1;
               s1_vld_q   <= 1'b0;
               conflict_q <= 1'b0;
               rdata_q    <= '0;
               rflags_q   <= '0;
               if (cnt_q == TW'(THREADS - 1)) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               s1_vld_q   <= wr_any_d;
               conflict_q <= conflict_d;
               if (thread_load_en) begin
                  rdata_q  <= ld_word_d[NREGS*DW-1:0];
                  rflags_q <= ld_word_d[NREGS*DW +: FW];
               end
            end
            default: begin
               state_q <= ST_INIT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // S1 payload: captured whenever a RUN cycle carries any enable. No reset is needed
   // because s1_vld_q qualifies it.
   always_ff @(posedge clk) begin
      if ((state_q == ST_RUN) && wr_any_d) begin
         s1_thread_q <= wb_thread;
         s1_data_q   <= s1_data_d;
         s1_mask_q   <= s1_mask_d;
      end
   end

   // Context storage: either the INIT sweep clears one context, or S1 commits its masked write.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT)
         mem_q[cnt_q] <= '0;
      else if (rst && s1_vld_q)
         mem_q[s1_thread_q] <= (mem_q[s1_thread_q] & ~s1_mask_q) | s1_data_q;
   end

   assign ready       = ready_q;
   assign rdata       = rdata_q;
   assign rflags      = rflags_q;
   assign wb_conflict = conflict_q;

endmodule

// File: tb/tb_tawas_regfile_mp.sv
// Self-checking bench for tawas_regfile_mp. It keeps a reference model of the
// register file contents. Loads see the contents as they stood before the
// current cycle's writeback. Writebacks are applied in port order, so the
// highest-numbered port wins a lane.
module tb_tawas_regfile_mp;
   localparam int THREADS = 32;
   localparam int NREGS   = 8;
   localparam int DW      = 32;
   localparam int FW      = 8;
   localparam int NWB     = 3;
   localparam int TW      = $clog2(THREADS);
   localparam int RW      = $clog2(NREGS);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 ready;
   logic                 thread_load_en;
   logic [TW-1:0]        thread_load;
   logic [NREGS*DW-1:0]  rdata;
   logic [FW-1:0]        rflags;
   logic [TW-1:0]        wb_thread;
   logic [NWB-1:0]       wb_en;
   logic [NWB*RW-1:0]    wb_reg;
   logic [NWB*DW-1:0]    wb_data;
   logic                 wb_flags_en;
   logic [FW-1:0]        wb_flags;
   logic                 wb_conflict;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0]        m_reg [THREADS][NREGS];
   logic [FW-1:0]        m_flg [THREADS];
   logic [NREGS*DW-1:0]  exp_rdata;
   logic [FW-1:0]        exp_rflags;
   logic                 exp_conf;

   tawas_regfile_mp #(
      .THREADS(THREADS), .NREGS(NREGS), .DW(DW), .FW(FW), .NWB(NWB)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .thread_load_en(thread_load_en), .thread_load(thread_load),
      .rdata(rdata), .rflags(rflags),
      .wb_thread(wb_thread), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .wb_flags_en(wb_flags_en), .wb_flags(wb_flags), .wb_conflict(wb_conflict)
   );

   always #5 clk = ~clk;

   task automatic clear_model();
      for (int t = 0; t < THREADS; t++) begin
         m_flg[t] = '0;
         for (int r = 0; r < NREGS; r++) m_reg[t][r] = '0;
      end
   endtask

   task automatic idle();
      thread_load_en = 1'b0;
      wb_en          = '0;
      wb_flags_en    = 1'b0;
   endtask

   // Advance one clock. The expected outputs are computed from the model first,
   // then this cycle's writeback is folded into the model.
   task automatic step();
      logic [NREGS-1:0] hit;
      int r;
      if (!rst) begin
         clear_model();
         exp_rdata  = '0;
         exp_rflags = '0;
         exp_conf   = 1'b0;
      end else if (ready !== 1'b1) begin
         exp_rdata  = '0;
         exp_rflags = '0;
         exp_conf   = 1'b0;
      end else begin
         if (thread_load_en) begin
            for (int i = 0; i < NREGS; i++) exp_rdata[i*DW +: DW] = m_reg[thread_load][i];
            exp_rflags = m_flg[thread_load];
         end
         hit = '0;
         exp_conf = 1'b0;
         for (int p = 0; p < NWB; p++) begin
            if (wb_en[p]) begin
               r = int'(wb_reg[p*RW +: RW]);
               if (hit[r]) exp_conf = 1'b1;
               hit[r] = 1'b1;
               m_reg[wb_thread][r] = wb_data[p*DW +: DW];
            end
         end
         if (wb_flags_en) m_flg[wb_thread] = wb_flags;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input int r, input logic [DW-1:0] d);
      wb_en[p]            = 1'b1;
      wb_reg[p*RW +: RW]  = RW'(r);
      wb_data[p*DW +: DW] = d;
   endtask

   task automatic test_reset();
      int low;
      rst = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      clear_model();
      exp_rdata = '0; exp_rflags = '0; exp_conf = 1'b0;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++;
      if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++;
      if (rflags !== '0) begin errors++; $display("FAIL reset_rflags: got %h expected 0", rflags); end
      checks++;
      if (wb_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", wb_conflict); end
      rst = 1'b1;
      low = 0;
      while (ready !== 1'b1 && low < 200) begin
         low++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (low != THREADS) begin errors++; $display("FAIL init_length: got %0d cycles expected %0d", low, THREADS); end
      thread_load_en = 1'b1;
      thread_load    = TW'(5);
      step();
      idle();
      checks++;
      if (rdata !== '0) begin errors++; $display("FAIL load_after_init_rdata: got %h expected 0", rdata); end
      checks++;
      if (rflags !== '0) begin errors++; $display("FAIL load_after_init_rflags: got %h expected 0", rflags); end
   endtask

   task automatic test_bypass();
      idle();
      wb_thread   = TW'(3);
      set_port(0, 2, 32'h1111_1111);
      wb_flags_en = 1'b1;
      wb_flags    = 8'hA5;
      step();
      idle();
      thread_load_en = 1'b1;
      thread_load    = TW'(3);
      step();
      idle();
      checks++;
      if (rdata[2*DW +: DW] !== 32'h1111_1111) begin errors++; $display("FAIL bypass_reg2: got %h expected 11111111", rdata[2*DW +: DW]); end
      checks++;
      if (rflags !== 8'hA5) begin errors++; $display("FAIL bypass_flags: got %h expected a5", rflags); end
      checks++;
      if (rdata !== exp_rdata) begin errors++; $display("FAIL bypass_other_regs: got %h expected %h", rdata, exp_rdata); end
      checks++;
      if (wb_conflict !== 1'b0) begin errors++; $display("FAIL bypass_no_conflict: got %b expected 0", wb_conflict); end
   endtask

   task automatic test_conflict();
      idle();
      wb_thread = TW'(1);
      set_port(0, 4, 32'hAAAA_0000);
      set_port(2, 4, 32'h0000_BBBB);
      step();
      idle();
      checks++;
      if (wb_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", wb_conflict); end
      step();
      checks++;
      if (wb_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clears: got %b expected 0", wb_conflict); end
      thread_load_en = 1'b1;
      thread_load    = TW'(1);
      step();
      idle();
      checks++;
      if (rdata[4*DW +: DW] !== 32'h0000_BBBB) begin errors++; $display("FAIL conflict_winner: got %h expected 0000bbbb", rdata[4*DW +: DW]); end
   endtask

   task automatic test_back_to_back();
      idle();
      wb_thread = TW'(7);
      set_port(0, 0, 32'hA1A1_A1A1);
      thread_load_en = 1'b1; thread_load = TW'(7);
      step();
      checks++;
      if (rdata[0 +: DW] !== 32'h0) begin errors++; $display("FAIL b2b_first_load: got %h expected 0", rdata[0 +: DW]); end
      idle();
      wb_thread = TW'(7);
      set_port(1, 1, 32'hB2B2_B2B2);
      thread_load_en = 1'b1; thread_load = TW'(7);
      step();
      checks++;
      if ((rdata[0 +: DW] !== 32'hA1A1_A1A1) || (rdata[DW +: DW] !== 32'h0)) begin
         errors++; $display("FAIL b2b_second_load: got r0=%h r1=%h expected r0=a1a1a1a1 r1=0", rdata[0 +: DW], rdata[DW +: DW]);
      end
      idle();
      wb_thread = TW'(9);
      set_port(2, 3, 32'hC3C3_C3C3);
      thread_load_en = 1'b1; thread_load = TW'(7);
      step();
      checks++;
      if (rdata[DW +: DW] !== 32'hB2B2_B2B2) begin errors++; $display("FAIL b2b_third_load: got %h expected b2b2b2b2", rdata[DW +: DW]); end
      idle();
      thread_load_en = 1'b1; thread_load = TW'(9);
      step();
      idle();
      checks++;
      if (rdata[3*DW +: DW] !== 32'hC3C3_C3C3) begin errors++; $display("FAIL b2b_thread9: got %h expected c3c3c3c3", rdata[3*DW +: DW]); end
      checks++;
      if (rdata !== exp_rdata) begin errors++; $display("FAIL b2b_full: got %h expected %h", rdata, exp_rdata); end
   endtask

   task automatic test_same_cycle();
      idle();
      wb_thread = TW'(0);
      set_port(0, 5, 32'h0000_0055);
      step();
      idle();
      step();
      wb_thread = TW'(0);
      set_port(1, 5, 32'h0000_0066);
      thread_load_en = 1'b1; thread_load = TW'(0);
      step();
      idle();
      checks++;
      if (rdata[5*DW +: DW] !== 32'h0000_0055) begin errors++; $display("FAIL same_cycle_old: got %h expected 00000055", rdata[5*DW +: DW]); end
      thread_load_en = 1'b1; thread_load = TW'(0);
      step();
      idle();
      checks++;
      if (rdata[5*DW +: DW] !== 32'h0000_0066) begin errors++; $display("FAIL same_cycle_new: got %h expected 00000066", rdata[5*DW +: DW]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wb_thread      = TW'($urandom_range(0, 3));
         wb_en          = NWB'($urandom);
         wb_reg         = (NWB*RW)'($urandom);
         wb_data        = {$urandom, $urandom, $urandom};
         wb_flags_en    = ($urandom_range(0, 3) == 0);
         wb_flags       = FW'($urandom);
         thread_load_en = ($urandom_range(0, 1) == 1);
         thread_load    = TW'($urandom_range(0, 3));
         step();
         checks++;
         if (rdata !== exp_rdata) begin errors++; $display("FAIL random_rdata[%0d]: got %h expected %h", i, rdata, exp_rdata); end
         checks++;
         if (rflags !== exp_rflags) begin errors++; $display("FAIL random_rflags[%0d]: got %h expected %h", i, rflags, exp_rflags); end
         checks++;
         if (wb_conflict !== exp_conf) begin errors++; $display("FAIL random_conflict[%0d]: got %b expected %b", i, wb_conflict, exp_conf); end
      end
      idle();
   endtask

   task automatic test_reset_mid_run();
      int low;
      idle();
      wb_thread = TW'(2);
      set_port(0, 6, 32'hDEAD_BEEF);
      wb_flags_en = 1'b1; wb_flags = 8'h3C;
      step();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      low = 0;
      while (ready !== 1'b1 && low < 200) begin
         low++;
         wb_en = NWB'($urandom); wb_flags_en = 1'b1; thread_load_en = 1'b1;
         step();
      end
      idle();
      checks++;
      if (low != THREADS) begin errors++; $display("FAIL midrun_init_length: got %0d expected %0d", low, THREADS); end
      thread_load_en = 1'b1; thread_load = TW'(2);
      step();
      idle();
      checks++;
      if ((rdata !== '0) || (rflags !== '0)) begin errors++; $display("FAIL midrun_thread2_zero: got %h/%h expected 0/0", rdata, rflags); end
   endtask

   task automatic test_reset_mid_init();
      int low;
      idle();
      wb_thread = TW'(6);
      set_port(0, 1, 32'h1234_5678);
      step();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      repeat (10) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      low = 0;
      while (ready !== 1'b1 && low < 200) begin
         low++;
         step();
      end
      checks++;
      if (low != THREADS) begin errors++; $display("FAIL midinit_init_length: got %0d expected %0d", low, THREADS); end
      thread_load_en = 1'b1; thread_load = TW'(6);
      step();
      idle();
      checks++;
      if (rdata !== '0) begin errors++; $display("FAIL midinit_thread6_zero: got %h expected 0", rdata); end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      thread_load = '0;
      wb_thread   = '0;
      wb_reg      = '0;
      wb_data     = '0;
      wb_flags    = '0;
      test_reset();
      test_bypass();
      test_conflict();
      test_back_to_back();
      test_same_cycle();
      test_random();
      test_reset_mid_run();
      test_reset_mid_init();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/tawas_regfile_mp.md
TAWAS_REGFILE_MP -- requirements
Module: tawas_regfile_mp

Interface
REQ-001 Parameter THREADS, default 32: number of thread contexts; power of 2, ≥2; TW=log2(THREADS).
REQ-002 Parameter NREGS, default 8: registers per context; power of 2, ≥2; RW=log2(NREGS).
REQ-003 Parameter DW, default 32: register width in bits.
REQ-004 Parameter FW, default 8: flags field width per context.
REQ-005 Parameter NWB, default 3: number of register writeback ports.
REQ-006 The block SHALL use one clock; reset SHALL be synchronous and active-low, with ports named clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-low reset.
REQ-009 ready  output  1  high when initialisation is complete.
REQ-010 thread_load_en  input  1  load-context request.
REQ-011 thread_load  input  TW  thread whose context is loaded.
REQ-012 rdata  output  NREGS*DW  loaded registers; reg i at bits [i*DW +: DW].
REQ-013 rflags  output  FW  loaded flags.
REQ-014 wb_thread  input  TW  target thread for all writeback ports this cycle.
REQ-015 wb_en  input  NWB  per-port register write enable.
REQ-016 wb_reg  input  NWB*RW  per-port register index; port p at [p*RW +: RW].
REQ-017 wb_data  input  NWB*DW  per-port write data; port p at [p*DW +: DW].
REQ-018 wb_flags_en  input  1  flags write enable.
REQ-019 wb_flags  input  FW  flags write data.
REQ-020 wb_conflict  output  1  registered pulse: two or more enabled ports targeted the same register.

Function
REQ-021 Storage: THREADS contexts of NREGS*DW+FW bits each.
REQ-022 State machine: INIT, RUN. Reset enters INIT with sweep counter 0.
REQ-023 INIT: each cycle, write context[counter] to all-zero and increment; after context THREADS-1 is written, go to RUN next cycle; INIT lasts exactly THREADS cycles.
REQ-024 ready SHALL be 0 in INIT and 1 in RUN.
REQ-025 In INIT, thread_load_en, wb_en and wb_flags_en are ignored; rdata/rflags hold 0.
REQ-026 Write pipeline: in RUN, a cycle with any enable set captures thread, merged data and merged mask into stage S1 (S1 valid); the next cycle S1 is applied as mem = (mem & ~mask) | data.
REQ-027 Merge: each enabled port sets its register lane in mask and data; flags lane set by wb_flags_en.
REQ-028 Same-register collision: the highest-index enabled port wins the lane; lower ports to that lane are dropped.
REQ-029 wb_conflict SHALL be 1 in the cycle after any collision, else 0.
REQ-030 Load: thread_load_en in RUN at cycle L updates rdata/rflags at cycle L+1; otherwise they hold.
REQ-031 Bypass: if S1 is valid for the same thread as the load in cycle L, loaded value = (mem & ~S1.mask) | S1.data.
REQ-032 Visibility: a writeback presented in cycle N SHALL be seen by any load issued in cycle N+1 or later; a load in cycle N SHALL see pre-N contents.
REQ-033 Back-to-back writebacks to the same or different threads every cycle SHALL be accepted without loss; no stall exists.
REQ-034 Lanes not in mask SHALL retain their prior value.

Reset
REQ-035 Reset low at a rising edge: state INIT, counter 0, S1 invalid, ready 0, rdata 0, rflags 0, wb_conflict 0.
REQ-036 Reset asserted mid-RUN or mid-INIT SHALL discard S1 and restart the full INIT sweep; all contexts read 0 afterwards.

Verification
REQ-037 Release reset -> ready low exactly THREADS cycles then high; load thread 5 -> rdata=0, rflags=0.
REQ-038 Cycle N: thread 3, port0 reg2=0x11111111, flags=0xA5; cycle N+1 load thread 3 -> at N+2 reg2=0x11111111, rflags=0xA5, other regs 0 (bypass path).
REQ-039 Ports 0 and 2 both to thread 1 reg4 (0xAAAA0000, 0x0000BBBB) -> wb_conflict=1 next cycle; later load gives reg4=0x0000BBBB.
REQ-040 Writebacks on three consecutive cycles to threads 7,7,9 distinct regs, loads interleaved -> each load reflects all earlier writes, none of later.
REQ-041 Assert reset with S1 valid for thread 2 -> after INIT, thread 2 reads all zero.
REQ-042 Load thread 0 in same cycle as write to thread 0 -> rdata shows old value; load next cycle shows new value.
